// File: rtl/pll_reset_sequencer_pkg.sv
// Shared definitions for the PLL reset/lock sequencer.
// Holds the per-channel state encoding, the loss-counter and retry-counter widths, and a
// helper that sizes the shared per-channel cycle counter.
package pll_seq_pkg;

    localparam int unsigned LOSS_CNT_W = 8;
    localparam int unsigned RETRY_W    = 4;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StReset    = 3'd1,
        StWaitLock = 3'd2,
        StStable   = 3'd3,
        StRun      = 3'd4,
        StFault    = 3'd5
    } chan_state_e;

    // One counter serves the reset pulse, the lock timeout and the stability window, so it is
    // sized for the longest of the three.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Bundle of per-channel control/status signals between the sequencer and its environment.
//   enable     : per-channel run request (into the sequencer)
//   locked_in  : raw PLL LOCKED bits, asynchronous (into the sequencer)
//   pll_rst    : active-high PLL resets (from the sequencer)
//   ready      : channel locked and stable (from the sequencer)
//   all_ready  : AND of all ready bits (from the sequencer)
//   fault      : channel exhausted its retries (from the sequencer)
//   loss_count : 8 bits per channel, channel i at [8i+7:8i] (from the sequencer)
// The sequencer connects through the slave modport; the environment uses master.
interface pll_reset_sequencer_if #(
    parameter int unsigned NUM_PLLS = 2
);
    import pll_seq_pkg::*;

    logic [NUM_PLLS-1:0]            enable;
    logic [NUM_PLLS-1:0]            locked_in;
    logic [NUM_PLLS-1:0]            pll_rst;
    logic [NUM_PLLS-1:0]            ready;
    logic                           all_ready;
    logic [NUM_PLLS-1:0]            fault;
    logic [LOSS_CNT_W*NUM_PLLS-1:0] loss_count;

    modport master (
        output enable,
        output locked_in,
        input  pll_rst,
        input  ready,
        input  all_ready,
        input  fault,
        input  loss_count
    );

    modport slave (
        input  enable,
        input  locked_in,
        output pll_rst,
        output ready,
        output all_ready,
        output fault,
        output loss_count
    );

endinterface

// File: rtl/pll_reset_sequencer_chan.sv
// One PLL channel: lock synchroniser, reset/lock FSM, cycle counter, retry counter and
// saturating lock-loss counter.
//   clk, rst   : reference clock, asynchronous active-high reset
//   enable     : run request for this channel
//   locked_in  : raw PLL LOCKED, asynchronous to clk
//   pll_rst    : registered PLL reset (high in idle, reset and fault)
//   ready      : registered, high while running
//   fault      : registered, high once retries are exhausted
//   loss_count : lock losses seen while running, saturating
module pll_chan_seq
    import pll_seq_pkg::*;
#(
    parameter int unsigned RESET_CYCLES  = 16,
    parameter int unsigned LOCK_TIMEOUT  = 65536,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  locked_in,
    output logic                  pll_rst,
    output logic                  ready,
    output logic                  fault,
    output logic [LOSS_CNT_W-1:0] loss_count
);

    localparam int unsigned CNT_W = cnt_width(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

    localparam logic [CNT_W-1:0]   RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

    logic lock_meta_q;
    logic lock_s;

    chan_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [RETRY_W-1:0]    retry_q, retry_d, retry_inc;
    logic [LOSS_CNT_W-1:0] loss_q, loss_d;

    // Two-flop synchroniser for the asynchronous LOCKED input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_meta_q <= 1'b0;
            lock_s      <= 1'b0;
        end else begin
            lock_meta_q <= locked_in;
            lock_s      <= lock_meta_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        retry_d   = retry_q;
        loss_d    = loss_q;
        retry_inc = retry_q + 1'b1;

        if (!enable) begin
            // Dropping the request overrides every other transition.
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d = StReset;
                    cnt_d   = '0;
                    retry_d = '0;
                end
                StReset: begin
                    if (cnt_q == RESET_LAST) begin
                        state_d = StWaitLock;
                        cnt_d   = '0;
                    end
                end
                StWaitLock: begin
                    // Lock beats a timeout on the same cycle.
                    if (lock_s) begin
                        state_d = StStable;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        retry_d = retry_inc;
                        cnt_d   = '0;
                        state_d = (retry_inc == RETRY_LIMIT) ? StFault : StReset;
                    end
                end
                StStable: begin
                    // A lock glitch restarts the timeout but costs no retry.
                    if (!lock_s) begin
                        state_d = StWaitLock;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = StRun;
                        cnt_d   = '0;
                        retry_d = '0;
                    end
                end
                StRun: begin
                    cnt_d = '0;
                    if (!lock_s) begin
                        state_d = StReset;
                        loss_d  = (loss_q == '1) ? loss_q : loss_q + 1'b1;
                    end
                end
                StFault: begin
                    cnt_d = '0;
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from next-state so they change on the same edge as the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            retry_q <= '0;
            loss_q  <= '0;
            pll_rst <= 1'b1;
            ready   <= 1'b0;
            fault   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            loss_q  <= loss_d;
            pll_rst <= (state_d == StIdle) || (state_d == StReset) || (state_d == StFault);
            ready   <= (state_d == StRun);
            fault   <= (state_d == StFault);
        end
    end

    assign loss_count = loss_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Reset/lock sequencer for up to eight PLL/MMCM instances. Each channel runs its own
// independent sequencer; all_ready is the combinational AND of the registered ready bits.
//   clk : free-running reference clock
//   rst : asynchronous active-high reset
//   bus : pll_reset_sequencer_if slave (enable, locked_in in; pll_rst, ready, all_ready,
//         fault, loss_count out)
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned NUM_PLLS      = 2,
    parameter int unsigned RESET_CYCLES  = 16,
    parameter int unsigned LOCK_TIMEOUT  = 65536,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    pll_reset_sequencer_if.slave  bus
);

    logic [NUM_PLLS-1:0]            pll_rst_v;
    logic [NUM_PLLS-1:0]            ready_v;
    logic [NUM_PLLS-1:0]            fault_v;
    logic [LOSS_CNT_W*NUM_PLLS-1:0] loss_v;

    for (genvar i = 0; i < NUM_PLLS; i++) begin : g_chan
        pll_chan_seq #(
            .RESET_CYCLES  (RESET_CYCLES),
            .LOCK_TIMEOUT  (LOCK_TIMEOUT),
            .STABLE_CYCLES (STABLE_CYCLES),
            .MAX_RETRIES   (MAX_RETRIES)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .enable     (bus.enable[i]),
            .locked_in  (bus.locked_in[i]),
            .pll_rst    (pll_rst_v[i]),
            .ready      (ready_v[i]),
            .fault      (fault_v[i]),
            .loss_count (loss_v[LOSS_CNT_W*i +: LOSS_CNT_W])
        );
    end

    assign bus.pll_rst    = pll_rst_v;
    assign bus.ready      = ready_v;
    assign bus.fault      = fault_v;
    assign bus.loss_count = loss_v;
    assign bus.all_ready  = &ready_v;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: directed scenarios with literal timing expectations, plus a
// timestamp-based model of each channel compared against the outputs every cycle.
`timescale 1ns/1ps
module tb_pll_reset_sequencer;

    localparam int N  = 2;
    localparam int RC = 4;
    localparam int LT = 64;
    localparam int SC = 16;
    localparam int MR = 2;

    localparam int PH_IDLE = 0;
    localparam int PH_RST  = 1;
    localparam int PH_WAIT = 2;
    localparam int PH_STAB = 3;
    localparam int PH_RUN  = 4;
    localparam int PH_FLT  = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pll_reset_sequencer_if #(.NUM_PLLS(N)) bus();

    pll_reset_sequencer #(
        .NUM_PLLS      (N),
        .RESET_CYCLES  (RC),
        .LOCK_TIMEOUT  (LT),
        .STABLE_CYCLES (SC),
        .MAX_RETRIES   (MR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- channel model: phase plus time of entry ----------------
    int m_phase[N];
    int m_start[N];
    int m_retries[N];
    int m_loss[N];
    bit m_h0[N];
    bit m_h1[N];
    int cyc = 0;

    task automatic model_reset();
        for (int ch = 0; ch < N; ch++) begin
            m_phase[ch]   = PH_IDLE;
            m_start[ch]   = 0;
            m_retries[ch] = 0;
            m_loss[ch]    = 0;
            m_h0[ch]      = 1'b0;
            m_h1[ch]      = 1'b0;
        end
    endtask

    task automatic goto(input int ch, input int p);
        m_phase[ch] = p;
        m_start[ch] = cyc + 1;
    endtask

    task automatic model_step();
        cyc++;
        for (int ch = 0; ch < N; ch++) begin
            bit ls;
            int el;
            ls = m_h1[ch];              // LOCKED as sampled two edges ago
            el = cyc - m_start[ch];     // cycles already spent in this phase
            m_h1[ch] = m_h0[ch];
            m_h0[ch] = bus.locked_in[ch];
            if (!bus.enable[ch]) begin
                m_phase[ch] = PH_IDLE;
            end else begin
                case (m_phase[ch])
                    PH_IDLE: begin
                        goto(ch, PH_RST);
                        m_retries[ch] = 0;
                    end
                    PH_RST: if (el == RC - 1) goto(ch, PH_WAIT);
                    PH_WAIT: begin
                        if (ls) goto(ch, PH_STAB);
                        else if (el == LT - 1) begin
                            m_retries[ch]++;
                            goto(ch, (m_retries[ch] == MR) ? PH_FLT : PH_RST);
                        end
                    end
                    PH_STAB: begin
                        if (!ls) goto(ch, PH_WAIT);
                        else if (el == SC - 1) begin
                            goto(ch, PH_RUN);
                            m_retries[ch] = 0;
                        end
                    end
                    PH_RUN: begin
                        if (!ls) begin
                            goto(ch, PH_RST);
                            if (m_loss[ch] < 255) m_loss[ch]++;
                        end
                    end
                    default: ;
                endcase
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            logic [N-1:0]    e_rst, e_rdy, e_flt;
            logic [8*N-1:0]  e_loss;
            @(negedge clk);
            if (rst !== 1'b1) begin
                for (int ch = 0; ch < N; ch++) begin
                    e_rst[ch] = (m_phase[ch] == PH_IDLE) || (m_phase[ch] == PH_RST) ||
                                (m_phase[ch] == PH_FLT);
                    e_rdy[ch] = (m_phase[ch] == PH_RUN);
                    e_flt[ch] = (m_phase[ch] == PH_FLT);
                    e_loss[8*ch +: 8] = 8'(m_loss[ch]);
                end
                check($sformatf("model_pll_rst@%0d", cyc), 32'(bus.pll_rst), 32'(e_rst));
                check($sformatf("model_ready@%0d", cyc), 32'(bus.ready), 32'(e_rdy));
                check($sformatf("model_fault@%0d", cyc), 32'(bus.fault), 32'(e_flt));
                check($sformatf("model_all_ready@%0d", cyc), 32'(bus.all_ready), 32'(&e_rdy));
                check($sformatf("model_loss@%0d", cyc), 32'(bus.loss_count), 32'(e_loss));
            end
        end
    end

    // ---------------- PLL models: lock 10 cycles after reset release ----------------
    bit [N-1:0] pll_ok    = '0;
    bit [N-1:0] lock_kill = '0;
    int low_cnt[N];

    initial begin
        bus.locked_in = '0;
        for (int ch = 0; ch < N; ch++) low_cnt[ch] = 0;
        forever begin
            @(posedge clk);
            #1;
            for (int ch = 0; ch < N; ch++) begin
                if (bus.pll_rst[ch] !== 1'b0) low_cnt[ch] = 0;
                else if (low_cnt[ch] < 1000) low_cnt[ch]++;
                bus.locked_in[ch] = pll_ok[ch] && (low_cnt[ch] >= 10) && !lock_kill[ch];
            end
        end
    end

    // ---------------- helpers ----------------
    function automatic logic sig(input int which, input int ch);
        case (which)
            0:       return bus.pll_rst[ch];
            1:       return bus.ready[ch];
            2:       return bus.fault[ch];
            default: return bus.locked_in[ch];
        endcase
    endfunction

    // Counts falling edges until the selected bit reaches val; a timeout is a failed check.
    task automatic wait_for(input string name, input int which, input int ch, input logic val,
                            input int limit, output int n);
        n = 0;
        while (sig(which, ch) !== val && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (sig(which, ch) !== val) begin
            checks++;
            errors++;
            $display("FAIL %s: no change to %0b within %0d cycles", name, val, limit);
        end
    endtask

    localparam int S_RST = 0, S_RDY = 1, S_FLT = 2, S_LCK = 3;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int n;
        rst = 1'b0;
        bus.enable = '0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);

        check("reset_pll_rst", 32'(bus.pll_rst), 32'h3);
        check("reset_ready", 32'(bus.ready), 32'h0);
        check("reset_fault", 32'(bus.fault), 32'h0);
        check("reset_all_ready", 32'(bus.all_ready), 32'h0);
        check("reset_loss", 32'(bus.loss_count), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_pll_rst", 32'(bus.pll_rst), 32'h3);

        // Clean bring-up on both channels.
        pll_ok = 2'b11;
        bus.enable = 2'b11;
        wait_for("bringup_rst_fall", S_RST, 0, 1'b0, 50, n);
        check("bringup_reset_window", n, RC + 1);
        wait_for("bringup_lock", S_LCK, 0, 1'b1, 50, n);
        wait_for("bringup_ready", S_RDY, 0, 1'b1, 60, n);
        check("bringup_lock_to_ready", n, 19);
        check("bringup_all_ready", 32'(bus.all_ready), 32'h1);
        check("bringup_fault", 32'(bus.fault), 32'h0);

        bus.enable = '0;
        repeat (2) @(negedge clk);

        // Channel 0 never locks: two timeout windows, one reset between, then fault.
        pll_ok = 2'b10;
        bus.enable = 2'b11;
        wait_for("to_first_fall", S_RST, 0, 1'b0, 50, n);
        wait_for("to_first_window", S_RST, 0, 1'b1, 100, n);
        check("timeout_window_1", n, LT);
        wait_for("to_retry_reset", S_RST, 0, 1'b0, 20, n);
        check("timeout_retry_reset", n, RC);
        wait_for("to_fault", S_FLT, 0, 1'b1, 100, n);
        check("timeout_window_2", n, LT);
        check("fault_pll_rst", 32'(bus.pll_rst[0]), 32'h1);
        check("fault_ch1_ready", 32'(bus.ready[1]), 32'h1);
        check("fault_all_ready", 32'(bus.all_ready), 32'h0);

        // Leave fault via enable, then a fresh reset.
        bus.enable[0] = 1'b0;
        @(negedge clk);
        check("fault_cleared", 32'(bus.fault[0]), 32'h0);
        check("idle_after_fault", 32'(bus.pll_rst[0]), 32'h1);
        bus.enable[0] = 1'b1;
        wait_for("refresh_fall", S_RST, 0, 1'b0, 50, n);
        check("refresh_reset_window", n, RC + 1);
        wait_for("refresh_window_1", S_RST, 0, 1'b1, 100, n);
        check("refresh_no_fault", 32'(bus.fault[0]), 32'h0);
        wait_for("refresh_retry_reset", S_RST, 0, 1'b0, 20, n);
        // Drop enable so it is sampled on the very edge of the second timeout.
        repeat (LT - 1) @(negedge clk);
        bus.enable[0] = 1'b0;
        @(negedge clk);
        check("disable_beats_timeout_fault", 32'(bus.fault[0]), 32'h0);
        check("disable_beats_timeout_rst", 32'(bus.pll_rst[0]), 32'h1);

        // Lock glitch while channel 0 is at stable count 8.
        pll_ok[0] = 1'b1;
        bus.enable[0] = 1'b1;
        wait_for("glitch_lock", S_LCK, 0, 1'b1, 60, n);
        repeat (7) @(negedge clk);
        lock_kill[0] = 1'b1;
        @(negedge clk);
        lock_kill[0] = 1'b0;
        wait_for("glitch_relock", S_LCK, 0, 1'b1, 5, n);
        wait_for("glitch_ready", S_RDY, 0, 1'b1, 60, n);
        check("glitch_relock_to_ready", n, 19);
        check("glitch_no_loss", 32'(bus.loss_count[7:0]), 32'h0);

        // Lock loss in RUN.
        lock_kill[0] = 1'b1;
        wait_for("loss_lock_fall", S_LCK, 0, 1'b0, 5, n);
        wait_for("loss_ready_fall", S_RDY, 0, 1'b0, 10, n);
        check("loss_reaction", n, 3);
        check("loss_pll_rst", 32'(bus.pll_rst[0]), 32'h1);
        check("loss_count_1", 32'(bus.loss_count[7:0]), 32'h1);
        lock_kill[0] = 1'b0;
        for (int i = 1; i < 300; i++) begin
            wait_for("sat_ready", S_RDY, 0, 1'b1, 80, n);
            lock_kill[0] = 1'b1;
            wait_for("sat_drop", S_RDY, 0, 1'b0, 10, n);
            lock_kill[0] = 1'b0;
        end
        check("loss_saturated", 32'(bus.loss_count[7:0]), 32'd255);
        check("loss_ch1_untouched", 32'(bus.loss_count[15:8]), 32'h0);

        // Asynchronous reset between edges while running.
        wait_for("arst_ready", S_RDY, 0, 1'b1, 80, n);
        check("arst_pre_all_ready", 32'(bus.all_ready), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("arst_pll_rst", 32'(bus.pll_rst), 32'h3);
        check("arst_ready", 32'(bus.ready), 32'h0);
        check("arst_all_ready", 32'(bus.all_ready), 32'h0);
        check("arst_fault", 32'(bus.fault), 32'h0);
        check("arst_loss", 32'(bus.loss_count), 32'h0);
        repeat (2) @(negedge clk);
        bus.enable = '0;
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
